multiport_register_file: RTL

- Parametrised successor to the single-write-port register file, used in the pipelined datapath for both the integer and FP register banks.
- Provides two combinational read ports and two write ports: port A is integer/ALU writeback, port B is FP-unit writeback.
- Adds same-cycle write-to-read bypass, an optional hardwired zero register, and a post-reset clear sequencer that replaces file-based initialisation.
- Pipeline control must hold issue while `ready` is low.

---
 rtl/rf_pkg.sv | 14 +
 rtl/multiport_register_file_if.sv | 60 ++++++
 rtl/rf_clear_seq.sv | 53 +++++
 rtl/multiport_register_file.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the multiport register file.
// Imported by the clear sequencer and the register file top.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 6;
    localparam int RF_ZERO_ADDR  = 0;

endpackage

// File: rtl/multiport_register_file_if.sv
// Register file bus: two write ports, two read ports, ready,
// plus pending/issue signals when RF_SCOREBOARD_EN is defined.
interface multiport_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) ();

    logic              wr_en_a;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [DATA_W-1:0] wr_data_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [DATA_W-1:0] wr_data_b;
    logic [ADDR_W-1:0] rs_address;
    logic [ADDR_W-1:0] rt_address;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              ready;
`ifdef RF_SCOREBOARD_EN
    logic              pend_rs;
    logic              pend_rt;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    modport master (
        output wr_en_a, wr_addr_a, wr_data_a,
        output wr_en_b, wr_addr_b, wr_data_b,
        output rs_address, rt_address,
        output issue_en, issue_addr,
        input  read_data_1, read_data_2,
        input  ready, pend_rs, pend_rt
    );

    modport slave (
        input  wr_en_a, wr_addr_a, wr_data_a,
        input  wr_en_b, wr_addr_b, wr_data_b,
        input  rs_address, rt_address,
        input  issue_en, issue_addr,
        output read_data_1, read_data_2,
        output ready, pend_rs, pend_rt
    );
`else
    modport master (
        output wr_en_a, wr_addr_a, wr_data_a,
        output wr_en_b, wr_addr_b, wr_data_b,
        output rs_address, rt_address,
        input  read_data_1, read_data_2,
        input  ready
    );

    modport slave (
        input  wr_en_a, wr_addr_a, wr_data_a,
        input  wr_en_b, wr_addr_b, wr_data_b,
        input  rs_address, rt_address,
        output read_data_1, read_data_2,
        output ready
    );
`endif

endinterface

// File: rtl/rf_clear_seq.sv
// Post-reset clear sweep: CLEAR/RUN FSM, sweep index, ready.
// Ports: clk, reset (async low), clr_we/clr_idx to the array, ready.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                idx_d = idx_q;
            end
        endcase
    end

    assign clr_idx = idx_q;
    assign ready   = (state_q == RUN);

endmodule

// File: rtl/multiport_register_file.sv
// 2-read / 2-write register file with bypass, zero register and
// post-reset clear sweep. Bus via multiport_register_file_if.slave;
// clk and reset (async active-low) are plain ports.
// Optional pending scoreboard under macro RF_SCOREBOARD_EN.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                      clk,
    input logic                      reset,
    multiport_register_file_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              ready;
    logic              zero_a;
    logic              zero_b;
    logic              we_a;
    logic              we_b;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .ready   (ready)
    );

    assign zero_a = (ZERO_REG != 0) && (bus.wr_addr_a == ZADDR);
    assign zero_b = (ZERO_REG != 0) && (bus.wr_addr_b == ZADDR);
    assign we_a   = ready && bus.wr_en_a && !zero_a;
    assign we_b   = ready && bus.wr_en_b && !zero_b;

    // Contents are zeroed by the sweep, not by reset.
    // Port B is written last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else begin
            if (we_a) begin
                mem[bus.wr_addr_a] <= bus.wr_data_a;
            end
            if (we_b) begin
                mem[bus.wr_addr_b] <= bus.wr_data_b;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] q,
        input logic              rdy,
        input logic              wa,
        input logic [ADDR_W-1:0] aa,
        input logic [DATA_W-1:0] da,
        input logic              wb,
        input logic [ADDR_W-1:0] ab,
        input logic [DATA_W-1:0] db
    );
        logic [DATA_W-1:0] r;
        r = q;
        if (!rdy) begin
            r = '0;
        end else if (ZERO_REG != 0 && ra == ZADDR) begin
            r = '0;
        end else if (BYPASS != 0 && wb && ab == ra) begin
            r = db;
        end else if (BYPASS != 0 && wa && aa == ra) begin
            r = da;
        end
        return r;
    endfunction

    assign bus.read_data_1 = rd_mux(
        bus.rs_address, mem[bus.rs_address], ready,
        we_a, bus.wr_addr_a, bus.wr_data_a,
        we_b, bus.wr_addr_b, bus.wr_data_b);

    assign bus.read_data_2 = rd_mux(
        bus.rt_address, mem[bus.rt_address], ready,
        we_a, bus.wr_addr_a, bus.wr_data_a,
        we_b, bus.wr_addr_b, bus.wr_data_b);

    assign bus.ready = ready;

`ifdef RF_SCOREBOARD_EN
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             zero_i;

    assign zero_i = (ZERO_REG != 0) && (bus.issue_addr == ZADDR);

    // Set is applied after the clears so a back-to-back issue wins.
    always_comb begin
        pend_d = pend_q;
        if (we_a) begin
            pend_d[bus.wr_addr_a] = 1'b0;
        end
        if (we_b) begin
            pend_d[bus.wr_addr_b] = 1'b0;
        end
        if (ready && bus.issue_en && !zero_i) begin
            pend_d[bus.issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign bus.pend_rs = pend_q[bus.rs_address];
    assign bus.pend_rt = pend_q[bus.rt_address];
`endif

endmodule
